// File: rtl/round_key_store.sv
// round_key_store: round-key RAM filled by the key expander, read by the cipher datapath once the full schedule is locked
module round_key_store #(
  parameter int KEY_S = 128,
  parameter int NR = 10,
  parameter int AW = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [KEY_S-1:0] wr_key,
  input  logic             expand_done,
  input  logic             invalidate,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [KEY_S-1:0] rd_key,
  output logic             rd_valid,
  output logic             rd_err,
  output logic             wr_err,
  output logic             load_err,
  output logic             keys_ready
);
  typedef enum logic [1:0] {EMPTY, FILLING, READY} state_t;
  localparam logic [AW-1:0] LAST = AW'(NR);
  state_t state, state_n;
  logic [NR:0] valid, valid_n, wr_hot;
  logic [KEY_S-1:0] mem [0:NR];
  logic wr_ok, wr_bad, rd_ok, load_bad;
  always_comb begin
    wr_ok = wr_en && !invalidate && wr_addr <= LAST && state != READY;
    wr_bad = wr_en && !invalidate && (wr_addr > LAST || state == READY);
    rd_ok = rd_en && !invalidate && rd_addr <= LAST && state == READY;
    wr_hot = wr_ok ? {{NR{1'b0}}, 1'b1} << wr_addr : '0;
    state_n = state;
    valid_n = valid | wr_hot;
    load_bad = 1'b0;
    if (invalidate) begin
      state_n = EMPTY;
      valid_n = '0;
    end else if (expand_done && state != READY) begin
      // a write to the last slot in the same cycle counts toward completeness
      state_n = &valid_n ? READY : EMPTY;
      load_bad = !(&valid_n);
      valid_n = &valid_n ? valid_n : '0;
    end else if (wr_ok) begin
      state_n = FILLING;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
      valid <= '0;
      rd_key <= '0;
      rd_valid <= 1'b0;
      rd_err <= 1'b0;
      wr_err <= 1'b0;
      load_err <= 1'b0;
      keys_ready <= 1'b0;
    end else begin
      state <= state_n;
      valid <= valid_n;
      keys_ready <= state_n == READY;
      rd_valid <= rd_ok;
      rd_err <= rd_en && !rd_ok;
      wr_err <= wr_bad;
      load_err <= load_bad;
      if (rd_ok) rd_key <= mem[rd_addr];
    end
  end
  always_ff @(posedge clk) begin
    if (wr_ok && !reset) mem[wr_addr] <= wr_key;
  end
endmodule

// File: tb/tb_round_key_store.sv
// tb_round_key_store: scoreboard bench; stimulus pushes expected read responses, a negedge monitor pops and compares
module tb_round_key_store;
  localparam int KS = 128;
  localparam int NR = 10;
  localparam int AW = 4;
  logic clk = 0, reset = 0;
  logic wr_en = 0, expand_done = 0, invalidate = 0, rd_en = 0;
  logic [AW-1:0] wr_addr = 0, rd_addr = 0;
  logic [KS-1:0] wr_key = 0, rd_key;
  logic rd_valid, rd_err, wr_err, load_err, keys_ready;

  round_key_store #(.KEY_S(KS), .NR(NR), .AW(AW)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_key(wr_key),
    .expand_done(expand_done), .invalidate(invalidate), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_key(rd_key), .rd_valid(rd_valid), .rd_err(rd_err), .wr_err(wr_err),
    .load_err(load_err), .keys_ready(keys_ready)
  );

  always #5 clk = ~clk;

  typedef struct {bit err; logic [KS-1:0] key;} rd_t;
  rd_t rd_q[$];
  int checks = 0, errors = 0;
  int got_wr = 0, got_ld = 0, exp_wr = 0, exp_ld = 0;
  logic [KS-1:0] mmem [0:NR];
  bit [NR:0] mvalid = '0;
  bit mready = 0;
  logic [KS-1:0] last_key = '0;

  function automatic logic [KS-1:0] kval(int i, bit alt);
    logic [31:0] w = 32'hC0DE_0000 + 32'(i);
    return alt ? ~{4{w}} : {4{w}};
  endfunction

  task automatic chk(string name, logic [KS-1:0] got, logic [KS-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  rd_t e;
  always @(negedge clk) begin
    if (rd_valid || rd_err) begin
      if (rd_q.size() == 0) chk("rd_unexpected", {126'd0, rd_valid, rd_err}, '0);
      else begin
        e = rd_q.pop_front();
        chk("rd_valid", {127'd0, rd_valid}, {127'd0, !e.err});
        chk("rd_err", {127'd0, rd_err}, {127'd0, e.err});
        chk("rd_key", rd_key, e.key);
      end
    end
    if (wr_err) got_wr++;
    if (load_err) got_ld++;
  end

  task automatic drive(bit w, int wa, logic [KS-1:0] wk, bit ed, bit inv, bit r, int ra);
    bit ok = r && mready && ra <= NR && !inv;
    if (r) begin
      if (ok) last_key = mmem[ra];
      rd_q.push_back('{!ok, last_key});
    end
    if (w && !inv) begin
      if (wa > NR || mready) exp_wr++;
      else begin
        mmem[wa] = wk;
        mvalid[wa] = 1;
      end
    end
    if (ed && !inv && !mready) begin
      if (&mvalid) mready = 1;
      else begin
        mvalid = '0;
        exp_ld++;
      end
    end
    if (inv) begin
      mready = 0;
      mvalid = '0;
    end
    wr_en = w; wr_addr = AW'(wa); wr_key = wk; expand_done = ed;
    invalidate = inv; rd_en = r; rd_addr = AW'(ra);
    @(posedge clk); #1;
    wr_en = 0; expand_done = 0; invalidate = 0; rd_en = 0;
  endtask

  task automatic check_state(string tag);
    @(negedge clk); #1;
    chk({tag, "_ready"}, {127'd0, keys_ready}, {127'd0, mready});
    chk({tag, "_wr_err_cnt"}, KS'(got_wr), KS'(exp_wr));
    chk({tag, "_load_err_cnt"}, KS'(got_ld), KS'(exp_ld));
  endtask

  task automatic fill_all(bit alt);
    for (int i = 0; i < NR; i++) drive(1, i, kval(i, alt), 0, 0, 0, 0);
    drive(1, NR, kval(NR, alt), 1, 0, 0, 0);
  endtask

  initial begin
    #1 reset = 1;
    #1;
    chk("reset_outputs", {123'd0, rd_valid, rd_err, wr_err, load_err, keys_ready}, '0);
    chk("reset_rd_key", rd_key, '0);
    @(posedge clk); @(posedge clk); #1 reset = 0;

    // 1: ordered fill, expand_done alongside last write, back-to-back reads
    fill_all(0);
    check_state("t1");
    chk("t1_ready_hi", {127'd0, keys_ready}, 128'd1);
    drive(0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 1, 5);
    drive(0, 0, 0, 0, 0, 1, 10);
    check_state("t1_rd");
    chk("t1_k10", last_key, kval(10, 0));

    // 2: incomplete fill
    drive(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < NR; i++) drive(1, i, kval(i, 0), 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0);
    check_state("t2");
    chk("t2_load_err", KS'(exp_ld), 128'd1);
    drive(0, 0, 0, 0, 0, 1, 3);
    check_state("t2_rd");

    // 3: writes locked in READY, out-of-range read
    fill_all(0);
    drive(1, 4, {4{32'hDEAD_BEEF}}, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 4);
    drive(1, 15, 0, 0, 0, 1, 11);
    check_state("t3");
    chk("t3_k4", mmem[4], kval(4, 0));

    // 4: invalidate beats a same-cycle read, then refill with new keys
    drive(0, 0, 0, 0, 1, 1, 2);
    check_state("t4_inv");
    fill_all(1);
    for (int i = 0; i <= NR; i++) drive(0, 0, 0, 0, 0, 1, i);
    check_state("t4");

    // 5: async reset mid-fill clears live pulses immediately
    drive(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i <= 6; i++) drive(1, i, kval(i, 0), 0, 0, 0, 0);
    check_state("t5_pre");
    wr_en = 1; wr_addr = AW'(12);
    @(posedge clk); #1 wr_en = 0;
    chk("t5_wr_err_live", {127'd0, wr_err}, 128'd1);
    reset = 1;
    #1;
    chk("t5_reset_outputs", {123'd0, rd_valid, rd_err, wr_err, load_err, keys_ready}, '0);
    chk("t5_reset_rd_key", rd_key, '0);
    mvalid = '0; mready = 0; last_key = '0;
    @(posedge clk); #1 reset = 0;
    drive(0, 0, 0, 1, 0, 0, 0);
    check_state("t5");
    drive(0, 0, 0, 0, 0, 1, 0);

    // 6: random fills with duplicates and bad addresses against the model
    for (int r = 0; r < 2; r++) begin
      drive(0, 0, 0, 0, 1, 0, 0);
      for (int j = 0; j < 25; j++)
        drive(1, int'($urandom_range(0, 11)), {4{$urandom}}, 0, 0, 0, 0);
      for (int i = NR; i >= 0; i--)
        if (!mvalid[i]) drive(1, i, {4{$urandom}}, 0, 0, 0, 0);
      drive(1, int'($urandom_range(0, 10)), {4{$urandom}}, 1, 0, 0, 0);
      check_state("t6_fill");
      for (int j = 0; j < 14; j++) drive(0, 0, 0, 0, 0, 1, int'($urandom_range(0, 11)));
      check_state("t6_rd");
    end

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rd_q_drained", KS'(rd_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
